// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage next-PC sequencer with a 2-bit saturating branch history table.
// Chooses redirect / stall / predicted target / PC+4 and counts accepted redirects.
module fetch_pc_ctrl #(
  parameter int                XLEN      = 32,
  parameter logic [XLEN-1:0]   RESET_PC  = XLEN'(32'h8000_0000),
  parameter int                BHT_IDX_W = 4
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            F_stall_i,
  input  logic            mini_jmp_sel_i,
  input  logic            F_is_branch_i,
  input  logic [XLEN-1:0] mini_jmp_i,
  input  logic            E_redirect_i,
  input  logic [XLEN-1:0] E_redirect_pc_i,
  input  logic            E_train_valid_i,
  input  logic [XLEN-1:0] E_train_pc_i,
  input  logic            E_train_taken_i,
  output logic [XLEN-1:0] F_PC_o,
  output logic            F_valid_o,
  output logic            F_pred_taken_o,
  output logic            F_halt_o,
  output logic [31:0]     redirect_cnt_o
);

  localparam int BHT_N = 1 << BHT_IDX_W;

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALT} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [XLEN-1:0]       r_pc;
  logic [XLEN-1:0]       w_pc_next;
  logic [31:0]           r_cnt;
  logic [31:0]           w_cnt_next;
  logic [31:0]           w_cnt_inc;
  logic [1:0]            r_bht [BHT_N];
  logic [BHT_IDX_W-1:0]  w_fetch_idx;
  logic [BHT_IDX_W-1:0]  w_train_idx;
  logic [1:0]            w_bht_rd;
  logic [1:0]            w_bht_cur;
  logic [1:0]            w_bht_upd;
  logic                  w_redir_ok;
  logic                  w_pred;

  assign w_fetch_idx = r_pc[BHT_IDX_W+1:2];
  assign w_train_idx = E_train_pc_i[BHT_IDX_W+1:2];
  assign w_bht_rd    = r_bht[w_fetch_idx];
  assign w_bht_cur   = r_bht[w_train_idx];
  assign w_redir_ok  = E_redirect_i && (E_redirect_pc_i[1:0] == 2'b00);
  assign w_cnt_inc   = (r_cnt == 32'hFFFF_FFFF) ? r_cnt : r_cnt + 32'd1;

  // Prediction reads the table before any same-cycle training lands.
  assign w_pred = (r_state == ST_RUN) && mini_jmp_sel_i && (!F_is_branch_i || w_bht_rd[1]);

  always_comb begin
    if (E_train_taken_i) begin
      w_bht_upd = (w_bht_cur == 2'b11) ? 2'b11 : w_bht_cur + 2'b01;
    end else begin
      w_bht_upd = (w_bht_cur == 2'b00) ? 2'b00 : w_bht_cur - 2'b01;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_BOOT: w_state_next = ST_RUN;
      ST_RUN: begin
        if (E_redirect_i) begin
          if (w_redir_ok) begin
            w_pc_next  = E_redirect_pc_i;
            w_cnt_next = w_cnt_inc;
          end else begin
            w_state_next = ST_HALT;
          end
        end else if (F_stall_i) begin
          w_pc_next = r_pc;
        end else if (w_pred) begin
          w_pc_next = mini_jmp_i;
        end else begin
          w_pc_next = r_pc + XLEN'(4);
        end
      end
      ST_HALT: begin
        if (w_redir_ok) begin
          w_state_next = ST_RUN;
          w_pc_next    = E_redirect_pc_i;
          w_cnt_next   = w_cnt_inc;
        end
      end
      default: w_state_next = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_BOOT;
      r_pc    <= RESET_PC;
      r_cnt   <= 32'd0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Training is independent of sequencer state, so it continues through stall and halt.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < BHT_N; i++) begin
        r_bht[i] <= 2'b01;
      end
    end else if (E_train_valid_i) begin
      r_bht[w_train_idx] <= w_bht_upd;
    end
  end

  assign F_PC_o         = r_pc;
  assign F_valid_o      = (r_state == ST_RUN);
  assign F_halt_o       = (r_state == ST_HALT);
  assign F_pred_taken_o = w_pred;
  assign redirect_cnt_o = r_cnt;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed table-driven bench for fetch_pc_ctrl, plus a hand-written async reset sequence.
module tb_fetch_pc_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        F_stall_i;
  logic        mini_jmp_sel_i;
  logic        F_is_branch_i;
  logic [31:0] mini_jmp_i;
  logic        E_redirect_i;
  logic [31:0] E_redirect_pc_i;
  logic        E_train_valid_i;
  logic [31:0] E_train_pc_i;
  logic        E_train_taken_i;
  logic [31:0] F_PC_o;
  logic        F_valid_o;
  logic        F_pred_taken_o;
  logic        F_halt_o;
  logic [31:0] redirect_cnt_o;

  int total = 0;
  int bad   = 0;

  fetch_pc_ctrl #(
    .XLEN(32), .RESET_PC(32'h8000_0000), .BHT_IDX_W(4)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .F_stall_i(F_stall_i),
    .mini_jmp_sel_i(mini_jmp_sel_i), .F_is_branch_i(F_is_branch_i), .mini_jmp_i(mini_jmp_i),
    .E_redirect_i(E_redirect_i), .E_redirect_pc_i(E_redirect_pc_i),
    .E_train_valid_i(E_train_valid_i), .E_train_pc_i(E_train_pc_i), .E_train_taken_i(E_train_taken_i),
    .F_PC_o(F_PC_o), .F_valid_o(F_valid_o), .F_pred_taken_o(F_pred_taken_o),
    .F_halt_o(F_halt_o), .redirect_cnt_o(redirect_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        stall, sel, br;
    logic [31:0] jmp;
    logic        redir;
    logic [31:0] rpc;
    logic        tv;
    logic [31:0] tpc;
    logic        tt;
    logic [31:0] e_pc;
    logic        e_valid, e_pred, e_halt;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic stall, sel, br, input logic [31:0] jmp,
                     input logic redir, input logic [31:0] rpc,
                     input logic tv, input logic [31:0] tpc, input logic tt,
                     input logic [31:0] e_pc, input logic e_valid, e_pred, e_halt,
                     input logic [31:0] e_cnt);
    vec_t v;
    v.stall = stall; v.sel = sel; v.br = br; v.jmp = jmp;
    v.redir = redir; v.rpc = rpc; v.tv = tv; v.tpc = tpc; v.tt = tt;
    v.e_pc = e_pc; v.e_valid = e_valid; v.e_pred = e_pred; v.e_halt = e_halt; v.e_cnt = e_cnt;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic [31:0] pc, input logic v, p, h,
                         input logic [31:0] cnt);
    chk("pc", idx, F_PC_o, pc);
    chk("valid", idx, {31'd0, F_valid_o}, {31'd0, v});
    chk("pred", idx, {31'd0, F_pred_taken_o}, {31'd0, p});
    chk("halt", idx, {31'd0, F_halt_o}, {31'd0, h});
    chk("cnt", idx, redirect_cnt_o, cnt);
    $display("step %0d: pc=%h valid=%0b pred=%0b halt=%0b cnt=%0d",
             idx, F_PC_o, F_valid_o, F_pred_taken_o, F_halt_o, redirect_cnt_o);
  endtask

  task automatic idle_inputs();
    F_stall_i = 0; mini_jmp_sel_i = 0; F_is_branch_i = 0; mini_jmp_i = 0;
    E_redirect_i = 0; E_redirect_pc_i = 0;
    E_train_valid_i = 0; E_train_pc_i = 0; E_train_taken_i = 0;
  endtask

  localparam logic [31:0] B = 32'h8000_0000;

  initial begin
    rst_n_i = 1'b0;
    idle_inputs();

    //   st sl br jmp        rd rpc             tv tpc      tt  pc             v  p  h  cnt
    add(0, 1, 0, B+32'h100, 0, 0,             0, 0,       0,  B,             0, 0, 0, 0);
    add(0, 0, 0, 0,         0, 0,             0, 0,       0,  B,             1, 0, 0, 0);
    add(0, 1, 0, B+32'h100, 0, 0,             0, 0,       0,  B+32'h4,       1, 1, 0, 0);
    add(0, 0, 0, 0,         0, 0,             0, 0,       0,  B+32'h100,     1, 0, 0, 0);
    add(1, 0, 0, 0,         0, 0,             0, 0,       0,  B+32'h104,     1, 0, 0, 0);
    add(1, 1, 0, B+32'h900, 0, 0,             0, 0,       0,  B+32'h104,     1, 1, 0, 0);
    add(0, 0, 0, 0,         1, B+32'h10,      0, 0,       0,  B+32'h104,     1, 0, 0, 0);
    add(1, 1, 1, B+32'h400, 0, 0,             1, B+32'h10, 1, B+32'h10,      1, 0, 0, 1);
    add(1, 1, 1, B+32'h400, 0, 0,             1, B+32'h10, 1, B+32'h10,      1, 1, 0, 1);
    add(0, 1, 1, B+32'h400, 0, 0,             0, 0,       0,  B+32'h10,      1, 1, 0, 1);
    add(0, 0, 0, 0,         0, 0,             0, 0,       0,  B+32'h400,     1, 0, 0, 1);
    add(0, 0, 0, 0,         1, B+32'h10,      1, B+32'h10, 0, B+32'h404,     1, 0, 0, 1);
    add(1, 1, 1, B+32'h400, 0, 0,             1, B+32'h10, 0, B+32'h10,      1, 1, 0, 2);
    add(1, 1, 1, B+32'h400, 0, 0,             1, B+32'h10, 0, B+32'h10,      1, 0, 0, 2);
    add(1, 1, 1, B+32'h400, 0, 0,             1, B+32'h10, 0, B+32'h10,      1, 0, 0, 2);
    add(1, 1, 1, B+32'h400, 0, 0,             1, B+32'h10, 1, B+32'h10,      1, 0, 0, 2);
    add(1, 1, 1, B+32'h400, 0, 0,             0, 0,       0,  B+32'h10,      1, 0, 0, 2);
    add(1, 1, 0, B+32'h700, 1, B+32'h200,     0, 0,       0,  B+32'h10,      1, 1, 0, 2);
    add(0, 0, 0, 0,         0, 0,             0, 0,       0,  B+32'h200,     1, 0, 0, 3);
    add(0, 0, 0, 0,         1, B+32'h202,     0, 0,       0,  B+32'h204,     1, 0, 0, 3);
    add(0, 1, 0, B+32'h800, 0, 0,             0, 0,       0,  B+32'h204,     0, 0, 1, 3);
    add(0, 0, 0, 0,         1, B+32'h301,     1, B+32'h40, 1, B+32'h204,     0, 0, 1, 3);
    add(0, 0, 0, 0,         1, B+32'h300,     0, 0,       0,  B+32'h204,     0, 0, 1, 3);
    add(0, 1, 1, B+32'h500, 0, 0,             0, 0,       0,  B+32'h300,     1, 1, 0, 4);
    add(0, 0, 0, 0,         0, 0,             0, 0,       0,  B+32'h500,     1, 0, 0, 4);
    add(0, 0, 0, 0,         1, 32'hFFFF_FFFC, 0, 0,       0,  B+32'h504,     1, 0, 0, 4);
    add(0, 0, 0, 0,         0, 0,             0, 0,       0,  32'hFFFF_FFFC, 1, 0, 0, 5);
    add(0, 0, 0, 0,         0, 0,             0, 0,       0,  32'h0,         1, 0, 0, 5);

    repeat (2) @(negedge clk_i);
    #1 chk_all(-1, B, 0, 0, 0, 0);
    rst_n_i = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      F_stall_i = vq[i].stall; mini_jmp_sel_i = vq[i].sel; F_is_branch_i = vq[i].br;
      mini_jmp_i = vq[i].jmp; E_redirect_i = vq[i].redir; E_redirect_pc_i = vq[i].rpc;
      E_train_valid_i = vq[i].tv; E_train_pc_i = vq[i].tpc; E_train_taken_i = vq[i].tt;
      #1 chk_all(i, vq[i].e_pc, vq[i].e_valid, vq[i].e_pred, vq[i].e_halt, vq[i].e_cnt);
      @(negedge clk_i);
    end

    // Saturate the entry for 8000_0010 to taken, then reset asynchronously mid-redirect.
    idle_inputs();
    F_stall_i = 1; E_train_valid_i = 1; E_train_pc_i = B + 32'h10; E_train_taken_i = 1;
    repeat (2) @(negedge clk_i);
    idle_inputs();
    E_redirect_i = 1; E_redirect_pc_i = B + 32'h600; mini_jmp_sel_i = 1;
    #2 rst_n_i = 1'b0;
    #1 chk_all(100, B, 0, 0, 0, 0);
    @(negedge clk_i);
    #1 chk_all(101, B, 0, 0, 0, 0);
    idle_inputs();
    rst_n_i = 1'b1;
    #1 chk_all(102, B, 0, 0, 0, 0);
    @(negedge clk_i);
    E_redirect_i = 1; E_redirect_pc_i = B + 32'h10;
    #1 chk_all(103, B, 1, 0, 0, 0);
    @(negedge clk_i);
    idle_inputs();
    mini_jmp_sel_i = 1; F_is_branch_i = 1; mini_jmp_i = B + 32'h400;
    #1 chk_all(104, B + 32'h10, 1, 0, 0, 1);
    @(negedge clk_i);
    idle_inputs();
    #1 chk_all(105, B + 32'h14, 1, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
